core_if_fetch_buf: RTL and testbench

//  Instruction-fetch front end between the instruction memory bus and core_if_ifu; replaces the DPI ROM.

---
 rtl/core_if_fetch_buf.sv | 161 ++++++++++++++++
 tb/tb_core_if_fetch_buf.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_if_fetch_buf.sv
// Instruction fetch front end: owns the fetch PC, issues pipelined bus reads
// and buffers returned instructions with their PCs for the IFU.
module core_if_fetch_buf #(
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     INST_W   = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     MAX_OUTS = 2,
    parameter logic [PC_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush_req,
    input  logic [PC_W-1:0]   i_flush_pc,
    output logic              o_mem_req_valid,
    output logic [PC_W-1:0]   o_mem_req_addr,
    input  logic              i_mem_req_ready,
    input  logic              i_mem_rsp_valid,
    input  logic [INST_W-1:0] i_mem_rsp_inst,
    input  logic              i_mem_rsp_err,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [INST_W-1:0] o_inst,
    output logic [PC_W-1:0]   o_pc,
    output logic              o_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTS + 1);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic              err;
        logic [PC_W-1:0]   pc;
    } entry_t;

    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [OW-1:0]   outs_q, outs_d;
    logic [OW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    entry_t          fifo_q [DEPTH];

    logic [CW:0]     credit;
    logic [PC_W-1:0] flush_pc;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic            flush_lsb_unused;

    assign flush_lsb_unused = ^i_flush_pc[1:0];
    assign flush_pc = {i_flush_pc[PC_W-1:2], 2'b00};

    // Kept in-flight responses plus buffered entries must fit the FIFO,
    // so every response that is not dropped always finds a free slot.
    assign credit = (CW+1)'(outs_q - drop_q) + (CW+1)'(count_q);

    assign o_mem_req_valid = rst_n && !i_flush_req
                          && (outs_q < OW'(MAX_OUTS))
                          && (credit < (CW+1)'(DEPTH));
    assign o_mem_req_addr  = fetch_pc_q;

    assign req_fire = o_mem_req_valid && i_mem_req_ready;
    assign push     = i_mem_rsp_valid && (drop_q == '0) && !i_flush_req;
    assign pop      = o_valid && i_ready && !i_flush_req;

    assign o_valid = (count_q != '0);
    assign o_inst  = fifo_q[rd_ptr_q].inst;
    assign o_err   = fifo_q[rd_ptr_q].err;
    assign o_pc    = fifo_q[rd_ptr_q].pc;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        outs_d     = outs_q;
        drop_d     = drop_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + PC_W'(4);
            outs_d     = outs_d + OW'(1);
        end
        if (i_mem_rsp_valid && outs_q != '0) begin
            outs_d = outs_d - OW'(1);
        end
        if (i_mem_rsp_valid && drop_q != '0) begin
            drop_d = drop_q - OW'(1);
        end
        if (push) begin
            rsp_pc_d = rsp_pc_q + PC_W'(4);
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // Everything still in flight becomes stale, except a response
        // landing this very cycle, which is consumed here.
        if (i_flush_req) begin
            fetch_pc_d = flush_pc;
            rsp_pc_d   = flush_pc;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            if (i_mem_rsp_valid && outs_q != '0) begin
                drop_d = outs_q - OW'(1);
            end else begin
                drop_d = outs_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outs_q     <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outs_q     <= outs_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push) begin
            fifo_q[wr_ptr_q] <= '{
                inst: i_mem_rsp_inst,
                err:  i_mem_rsp_err,
                pc:   rsp_pc_q
            };
        end
    end

    rsp_has_request: assert property (
        @(posedge clk) disable iff (!rst_n)
        i_mem_rsp_valid |-> (outs_q != '0)
    );

endmodule

// File: tb/tb_core_if_fetch_buf.sv
// Directed bench for core_if_fetch_buf with an in-order bus responder
// and an expected-PC tracker for every instruction handed to the IFU.
module tb_core_if_fetch_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_flush_req;
    logic [31:0] i_flush_pc;
    logic        o_mem_req_valid;
    logic [31:0] o_mem_req_addr;
    logic        i_mem_req_ready;
    logic        i_mem_rsp_valid;
    logic [31:0] i_mem_rsp_inst;
    logic        i_mem_rsp_err;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        o_err;

    always #5 clk = ~clk;

    core_if_fetch_buf dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_flush_req     (i_flush_req),
        .i_flush_pc      (i_flush_pc),
        .o_mem_req_valid (o_mem_req_valid),
        .o_mem_req_addr  (o_mem_req_addr),
        .i_mem_req_ready (i_mem_req_ready),
        .i_mem_rsp_valid (i_mem_rsp_valid),
        .i_mem_rsp_inst  (i_mem_rsp_inst),
        .i_mem_rsp_err   (i_mem_rsp_err),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_inst          (o_inst),
        .o_pc            (o_pc),
        .o_err           (o_err)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc, lat_extra, n_req, n_pop, n_errpop;
    int          first_acc, first_v;
    bit          saw_zero;
    logic [31:0] exp_pc, err_addr;
    logic [31:0] pend_addr [$];
    int          pend_due [$];
    logic [31:0] acc_log [$];
    logic [31:0] pop_log [$];

    function automatic logic [31:0] inst_of(logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (o_mem_req_valid && i_mem_req_ready) begin
            pend_addr.push_back(o_mem_req_addr);
            pend_due.push_back(cyc + 1 + lat_extra);
            acc_log.push_back(o_mem_req_addr);
            n_req++;
            if (first_acc < 0) first_acc = cyc;
            if (o_mem_req_addr == 32'h0) saw_zero = 1'b1;
        end
        if (i_mem_rsp_valid) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (o_valid && first_v < 0) first_v = cyc;
        if (i_flush_req) begin
            chk("flush_noreq", {31'b0, o_mem_req_valid}, 32'h0);
            exp_pc = {i_flush_pc[31:2], 2'b00};
        end else if (o_valid && i_ready) begin
            chk("pop_pc", o_pc, exp_pc);
            chk("pop_inst", o_inst, inst_of(exp_pc));
            chk("pop_err", {31'b0, o_err}, {31'b0, exp_pc == err_addr});
            pop_log.push_back(o_pc);
            exp_pc += 32'd4;
            n_pop++;
            if (o_err) n_errpop++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            i_mem_rsp_valid = 1'b1;
            i_mem_rsp_inst  = inst_of(pend_addr[0]);
            i_mem_rsp_err   = (pend_addr[0] == err_addr);
        end else begin
            i_mem_rsp_valid = 1'b0;
            i_mem_rsp_inst  = 32'h0;
            i_mem_rsp_err   = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        i_flush_req     = 1'b0;
        i_flush_pc      = 32'h0;
        i_mem_req_ready = 1'b1;
        i_mem_rsp_valid = 1'b0;
        i_mem_rsp_inst  = 32'h0;
        i_mem_rsp_err   = 1'b0;
        i_ready         = 1'b1;
        lat_extra       = 0;
        err_addr        = 32'h1;
        pend_addr.delete();
        pend_due.delete();
        acc_log.delete();
        pop_log.delete();
        n_req     = 0;
        n_pop     = 0;
        n_errpop  = 0;
        first_acc = -1;
        first_v   = -1;
        saw_zero  = 1'b0;
        exp_pc    = 32'h8000_0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, o_valid}, 32'h0);
        chk("rst_req_valid", {31'b0, o_mem_req_valid}, 32'h0);
        rst_n = 1'b1;
        cyc   = 0;
        #1;
        chk("rst_addr", o_mem_req_addr, 32'h8000_0000);
    endtask

    task automatic flush(logic [31:0] pc);
        i_flush_req = 1'b1;
        i_flush_pc  = pc;
        tick();
        i_flush_req = 1'b0;
    endtask

    initial begin
        #2;
        // 1: streaming, single-cycle bus latency
        do_reset();
        repeat (12) tick();
        chk("t1_acc0", acc_log[0], 32'h8000_0000);
        chk("t1_acc1", acc_log[1], 32'h8000_0004);
        chk("t1_acc2", acc_log[2], 32'h8000_0008);
        chk("t1_lat", first_v - first_acc, 2);
        chk("t1_nreq", n_req, 12);
        chk("t1_npop", n_pop, 10);

        // 2: IFU stalled, buffer fills to DEPTH
        do_reset();
        i_ready = 1'b0;
        repeat (10) tick();
        chk("t2_nreq", n_req, 4);
        chk("t2_req_valid", {31'b0, o_mem_req_valid}, 32'h0);
        chk("t2_valid", {31'b0, o_valid}, 32'h1);
        i_ready = 1'b1;
        repeat (10) tick();
        chk("t2_resume", {31'b0, n_req > 4}, 32'h1);
        chk("t2_drain", {31'b0, n_pop >= 4}, 32'h1);

        // 3: flush with two requests in flight
        do_reset();
        lat_extra = 2;
        repeat (2) tick();
        acc_log.delete();
        pop_log.delete();
        lat_extra = 0;
        flush(32'h8000_0100);
        tick();
        chk("t3_nostale", {31'b0, o_valid}, 32'h0);
        repeat (8) tick();
        chk("t3_acc", acc_log[0], 32'h8000_0100);
        chk("t3_pop", pop_log[0], 32'h8000_0100);

        // 4: flush coinciding with a response and a pop
        do_reset();
        lat_extra = 1;
        i_ready   = 1'b0;
        repeat (5) tick();
        i_ready = 1'b1;
        chk("t4_pre_rsp", {31'b0, i_mem_rsp_valid}, 32'h1);
        chk("t4_pre_valid", {31'b0, o_valid}, 32'h1);
        pop_log.delete();
        lat_extra = 0;
        flush(32'h8000_0200);
        chk("t4_empty", {31'b0, o_valid}, 32'h0);
        tick();
        chk("t4_drop", {31'b0, o_valid}, 32'h0);
        repeat (8) tick();
        chk("t4_pop", pop_log[0], 32'h8000_0200);

        // 5: bus backpressure, varying latency, one erroring response
        do_reset();
        err_addr = 32'h8000_0008;
        for (int i = 0; i < 60; i++) begin
            i_mem_req_ready = (i % 2 == 0);
            lat_extra       = i % 4;
            i_ready         = (i % 3 != 2);
            tick();
        end
        i_mem_req_ready = 1'b0;
        i_ready         = 1'b1;
        repeat (12) tick();
        chk("t5_some", {31'b0, n_req >= 10}, 32'h1);
        chk("t5_noloss", n_pop, n_req);
        chk("t5_errcnt", n_errpop, 1);

        // 6: unaligned redirect target and PC wrap
        do_reset();
        repeat (2) tick();
        flush(32'h8000_0103);
        chk("t6_align", o_mem_req_addr, 32'h8000_0100);
        repeat (6) tick();
        pop_log.delete();
        saw_zero = 1'b0;
        flush(32'hFFFF_FFF8);
        repeat (10) tick();
        chk("t6_zero_req", {31'b0, saw_zero}, 32'h1);
        chk("t6_pop0", pop_log[0], 32'hFFFF_FFF8);
        chk("t6_pop1", pop_log[1], 32'hFFFF_FFFC);
        chk("t6_pop2", pop_log[2], 32'h0000_0000);
        chk("t6_pop3", pop_log[3], 32'h0000_0004);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
